// File: rtl/ee201_numlock_supervisor.sv
// Supervisor between the push buttons and the number lock: counts bad attempts and enforces a timed lockout.
// Build option: define NUMLOCK_ALARM_EN to enable the repeated-lockout Alarm output (otherwise Alarm is 0).
module ee201_numlock_supervisor #(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       U_in,
    input  logic       Z_in,
    input  logic       q_Bad,
    input  logic       q_Opening,
    output logic       U_out,
    output logic       Z_out,
    output logic       lock_reset,
    output logic       Locked_out,
    output logic [3:0] Fail_count,
    output logic       Alarm
);

    typedef enum logic [3:0] {
        QARM     = 4'b0001,
        QBADWAIT = 4'b0010,
        QLOCK    = 4'b0100,
        QCLEAR   = 4'b1000
    } state_t;

    localparam logic [3:0]  MAX_FAILS_L = 4'(MAX_FAILS);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCKOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  fail_q, fail_d;
    logic [15:0] timer_q, timer_d;
    logic        bad_dly_q;
    logic        bad_rise;
    logic [3:0]  fail_inc;
    logic        lock_reset_q, locked_out_q;
    logic        pass;

    assign bad_rise = q_Bad & ~bad_dly_q;
    assign fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        timer_d = '0;
        case (state_q)
            QARM: begin
                if (q_Opening) begin
                    fail_d = '0;
                end else if (bad_rise) begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == MAX_FAILS_L) ? QLOCK : QBADWAIT;
                end
            end
            QBADWAIT: begin
                if (!q_Bad) state_d = QARM;
            end
            QLOCK: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = QCLEAR;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            QCLEAR: begin
                // Wait for all buttons released so a held key cannot enter a digit.
                if (!U_in && !Z_in) begin
                    state_d = QARM;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = QARM;
                fail_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= QARM;
            fail_q       <= '0;
            timer_q      <= '0;
            bad_dly_q    <= 1'b0;
            lock_reset_q <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_q       <= fail_d;
            timer_q      <= timer_d;
            bad_dly_q    <= q_Bad;
            lock_reset_q <= (state_d == QLOCK);
            locked_out_q <= (state_d == QLOCK) || (state_d == QCLEAR);
        end
    end

    assign pass       = (state_q == QARM) || (state_q == QBADWAIT);
    assign U_out      = pass & U_in;
    assign Z_out      = pass & Z_in;
    assign lock_reset = lock_reset_q;
    assign Locked_out = locked_out_q;
    assign Fail_count = fail_q;

`ifdef NUMLOCK_ALARM_EN
    logic [1:0] lkcnt_q, lkcnt_d;
    logic       alarm_q, alarm_d;

    always_comb begin
        lkcnt_d = lkcnt_q;
        alarm_d = alarm_q;
        if ((state_q == QARM) && q_Opening) begin
            lkcnt_d = '0;
            alarm_d = 1'b0;
        end else if ((state_q != QLOCK) && (state_d == QLOCK)) begin
            lkcnt_d = (lkcnt_q == 2'd3) ? lkcnt_q : lkcnt_q + 2'd1;
        end
        if (lkcnt_d >= 2'd2) alarm_d = 1'b1;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            lkcnt_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            lkcnt_q <= lkcnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign Alarm = alarm_q;
`else
    assign Alarm = 1'b0;
`endif

endmodule

// File: tb/tb_ee201_numlock_supervisor.sv
// Directed bench for ee201_numlock_supervisor with MAX_FAILS=3, LOCKOUT_CYCLES=16.
module tb_ee201_numlock_supervisor;

    logic       Clk = 1'b0;
    logic       reset;
    logic       U_in, Z_in, q_Bad, q_Opening;
    logic       U_out, Z_out, lock_reset, Locked_out, Alarm;
    logic [3:0] Fail_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

`ifdef NUMLOCK_ALARM_EN
    localparam logic ALARM_EXP = 1'b1;
`else
    localparam logic ALARM_EXP = 1'b0;
`endif

    ee201_numlock_supervisor #(.MAX_FAILS(3), .LOCKOUT_CYCLES(16)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .U_in       (U_in),
        .Z_in       (Z_in),
        .q_Bad      (q_Bad),
        .q_Opening  (q_Opening),
        .U_out      (U_out),
        .Z_out      (Z_out),
        .lock_reset (lock_reset),
        .Locked_out (Locked_out),
        .Fail_count (Fail_count),
        .Alarm      (Alarm)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // q_Bad high for n clocks, then two idle clocks so the block is back in QArm.
    task automatic bad_pulse(input int n);
        q_Bad = 1'b1;
        repeat (n) step();
        q_Bad = 1'b0;
        step();
        step();
    endtask

    // Full lockout from a count of 0; returns the number of cycles Locked_out was high.
    task automatic lockout_full(output int len);
        repeat (2) bad_pulse(2);
        q_Bad = 1'b1;
        step();
        q_Bad = 1'b0;
        len = Locked_out ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Locked_out) len++;
            else break;
        end
    endtask

    initial begin
        reset = 1'b1; U_in = 1'b0; Z_in = 1'b0; q_Bad = 1'b0; q_Opening = 1'b0;
        step();
        step();
        chk("rst_lock_reset", lock_reset, 0);
        chk("rst_locked_out", Locked_out, 0);
        chk("rst_fail_count", Fail_count, 0);
        chk("rst_alarm", Alarm, 0);
        reset = 1'b0;
        step();

        U_in = 1'b1; #1;
        chk("pass_u", U_out, 1);
        chk("pass_z", Z_out, 0);
        chk("idle_fail_count", Fail_count, 0);
        chk("idle_lock_reset", lock_reset, 0);
        U_in = 1'b0; Z_in = 1'b1; #1;
        chk("pass_z_hi", Z_out, 1);
        Z_in = 1'b0;

        // Held q_Bad counts once
        q_Bad = 1'b1;
        repeat (3) step();
        chk("held_bad_count", Fail_count, 1);
        q_Bad = 1'b0;
        step(); step();
        bad_pulse(3);
        chk("two_bad_count", Fail_count, 2);
        chk("two_bad_no_lock", lock_reset, 0);
        chk("two_bad_locked_out", Locked_out, 0);

        // Third rise -> lockout
        q_Bad = 1'b1;
        step();
        chk("lock_entry_reset", lock_reset, 1);
        chk("lock_entry_locked", Locked_out, 1);
        chk("lock_entry_count", Fail_count, 3);
        U_in = 1'b1; Z_in = 1'b1; #1;
        chk("lock_gate_u", U_out, 0);
        chk("lock_gate_z", Z_out, 0);
        Z_in = 1'b0;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            q_Bad = 1'b0;
            if (lock_reset) cnt++;
            else break;
        end
        chk("lock_reset_len", cnt, 16);
        chk("clear_locked_out", Locked_out, 1);
        chk("clear_gate_u", U_out, 0);
        step(); step();
        chk("clear_hold_u", Locked_out, 1);
        chk("clear_count", Fail_count, 3);
        U_in = 1'b0;
        step();
        chk("clear_exit", Locked_out, 0);
        chk("clear_exit_count", Fail_count, 0);
        chk("clear_exit_alarm", Alarm, 0);
        U_in = 1'b1; #1;
        chk("arm_pass_again", U_out, 1);
        U_in = 1'b0;

        // Opening clears count
        bad_pulse(2);
        bad_pulse(2);
        chk("pre_open_count", Fail_count, 2);
        q_Opening = 1'b1;
        step();
        q_Opening = 1'b0;
        chk("open_clears", Fail_count, 0);
        step();
        bad_pulse(2);
        chk("post_open_count", Fail_count, 1);
        chk("post_open_no_lock", lock_reset, 0);

        // Reset at timer=7 in QLock
        bad_pulse(2);
        q_Bad = 1'b1;
        step();
        q_Bad = 1'b0;
        chk("lock2_entry", lock_reset, 1);
        repeat (7) step();
        chk("lock2_still", lock_reset, 1);
        reset = 1'b1; #1;
        chk("async_rst_lock_reset", lock_reset, 0);
        chk("async_rst_locked_out", Locked_out, 0);
        chk("async_rst_count", Fail_count, 0);
        step();
        reset = 1'b0;
        step();

        // Repeated lockouts and Alarm
        lockout_full(cnt);
        chk("lockout1_len", cnt, 17);
        chk("lockout1_alarm", Alarm, 0);
        lockout_full(cnt);
        chk("lockout2_len", cnt, 17);
        chk("lockout2_alarm", Alarm, ALARM_EXP);
        q_Opening = 1'b1;
        step();
        q_Opening = 1'b0;
        chk("open_clears_alarm", Alarm, 0);
        chk("open_count_final", Fail_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
